// File: rtl/avalon_msg_gen.sv
// Avalon-ST message source: one start command emits one framed message of
// msg_len bytes carrying an incrementing byte pattern that begins at seed.
module avalon_msg_gen #(
  parameter int DATA_WIDTH_IN_BYTES = 4,
  parameter int LEN_WIDTH           = 16,
  localparam int EMPTY_W = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [LEN_WIDTH-1:0]             msg_len,
  input  logic [7:0]                       seed,
  output logic                             ready_for_start,
  output logic                             len_err,
  output logic [15:0]                      msg_count,
  output logic [DATA_WIDTH_IN_BYTES*8-1:0] gen_msg_data,
  output logic                             gen_msg_valid,
  input  logic                             gen_msg_rdy,
  output logic                             gen_msg_sop,
  output logic                             gen_msg_eop,
  output logic [EMPTY_W-1:0]               gen_msg_empty
);

  localparam logic [LEN_WIDTH-1:0] DW_L = LEN_WIDTH'(DATA_WIDTH_IN_BYTES);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                           state_q, state_d;
  logic                             valid_q, valid_d;
  logic                             sop_q, sop_d;
  logic                             eop_q, eop_d;
  logic [EMPTY_W-1:0]               empty_q, empty_d;
  logic [DATA_WIDTH_IN_BYTES*8-1:0] data_q, data_d;
  logic                             len_err_q, len_err_d;
  logic [15:0]                      msg_count_q, msg_count_d;
  logic [LEN_WIDTH-1:0]             rem_q, rem_d;
  logic [7:0]                       next_byte_q, next_byte_d;

  logic                             accept, load_first, xfer, load_next, load;
  logic [LEN_WIDTH-1:0]             src_rem, beat_n, rem_after;
  logic [7:0]                       src_byte;
  logic                             beat_eop;
  logic [EMPTY_W-1:0]               beat_empty;
  logic [DATA_WIDTH_IN_BYTES*8-1:0] beat_data;

  assign accept     = start && (state_q == IDLE);
  assign load_first = accept && (msg_len != '0);
  assign xfer       = valid_q && gen_msg_rdy;
  assign load_next  = (state_q == SEND) && xfer && !eop_q;
  assign load       = load_first || load_next;

  // The beat builder works from either the fresh command or the bytes still owed.
  assign src_rem    = load_first ? msg_len : rem_q;
  assign src_byte   = load_first ? seed : next_byte_q;
  assign beat_n     = (src_rem >= DW_L) ? DW_L : src_rem;
  assign rem_after  = src_rem - beat_n;
  assign beat_eop   = (rem_after == '0);
  assign beat_empty = beat_eop ? EMPTY_W'(DW_L - beat_n) : '0;

  // Lane 0 sits in the most significant byte; lanes past the message end are zero.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_WIDTH_IN_BYTES; gi++) begin : g_lane
      assign beat_data[(DATA_WIDTH_IN_BYTES-1-gi)*8 +: 8] =
        (src_rem > LEN_WIDTH'(gi)) ? (src_byte + 8'(gi)) : 8'h00;
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    sop_d       = sop_q;
    eop_d       = eop_q;
    empty_d     = empty_q;
    data_d      = data_q;
    len_err_d   = 1'b0;
    msg_count_d = msg_count_q;
    rem_d       = rem_q;
    next_byte_d = next_byte_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (msg_len == '0) begin
            len_err_d = 1'b1;
          end else begin
            state_d = SEND;
          end
        end
      end
      SEND: begin
        if (xfer && eop_q) begin
          state_d     = IDLE;
          valid_d     = 1'b0;
          sop_d       = 1'b0;
          eop_d       = 1'b0;
          empty_d     = '0;
          data_d      = '0;
          msg_count_d = msg_count_q + 16'd1;
        end
      end
    endcase

    if (load) begin
      valid_d     = 1'b1;
      sop_d       = load_first;
      eop_d       = beat_eop;
      empty_d     = beat_empty;
      data_d      = beat_data;
      rem_d       = rem_after;
      next_byte_d = src_byte + 8'(beat_n);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      valid_q     <= 1'b0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      empty_q     <= '0;
      data_q      <= '0;
      len_err_q   <= 1'b0;
      msg_count_q <= '0;
      rem_q       <= '0;
      next_byte_q <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      sop_q       <= sop_d;
      eop_q       <= eop_d;
      empty_q     <= empty_d;
      data_q      <= data_d;
      len_err_q   <= len_err_d;
      msg_count_q <= msg_count_d;
      rem_q       <= rem_d;
      next_byte_q <= next_byte_d;
    end
  end

  assign ready_for_start = (state_q == IDLE);
  assign len_err         = len_err_q;
  assign msg_count       = msg_count_q;
  assign gen_msg_data    = data_q;
  assign gen_msg_valid   = valid_q;
  assign gen_msg_sop     = sop_q;
  assign gen_msg_eop     = eop_q;
  assign gen_msg_empty   = empty_q;

endmodule

// File: tb/tb_avalon_msg_gen.sv
// Bench for avalon_msg_gen: queue-of-beats reference model compared every
// cycle, directed scenarios pinned with literal beats, then random traffic.
module tb_avalon_msg_gen;
  localparam int DW = 4;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst, start, rdy;
  logic [LW-1:0] msg_len;
  logic [7:0]    seed;
  logic          rfs, len_err, valid, sop, eop;
  logic [15:0]   msg_count;
  logic [31:0]   data;
  logic [1:0]    empty;

  always #5 clk = ~clk;

  avalon_msg_gen #(.DATA_WIDTH_IN_BYTES(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .msg_len(msg_len), .seed(seed),
    .ready_for_start(rfs), .len_err(len_err), .msg_count(msg_count),
    .gen_msg_data(data), .gen_msg_valid(valid), .gen_msg_rdy(rdy),
    .gen_msg_sop(sop), .gen_msg_eop(eop), .gen_msg_empty(empty)
  );

  int total = 0;
  int bad = 0;
  bit checking = 0;
  int lenerr_seen = 0;
  int valid_cycles = 0;
  logic [31:0] cap_data[$];
  logic [1:0]  cap_empty[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: a message is a list of bytes seed+k, cut into beats.
  typedef struct {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [1:0]  empty;
  } beat_t;

  beat_t       mq[$];
  bit          m_busy = 0;
  bit          m_len_err = 0;
  int unsigned m_count = 0;

  task automatic build(input int len, input logic [7:0] sd);
    int nb;
    nb = (len + DW - 1) / DW;
    for (int b = 0; b < nb; b++) begin
      beat_t bt;
      int k;
      bt.data = '0;
      for (int i = 0; i < DW; i++) begin
        k = b * DW + i;
        if (k < len) bt.data[(DW-1-i)*8 +: 8] = 8'(int'(sd) + k);
      end
      bt.sop   = (b == 0);
      bt.eop   = (b == nb - 1);
      bt.empty = bt.eop ? 2'(nb * DW - len) : 2'd0;
      mq.push_back(bt);
    end
  endtask

  always @(posedge clk) begin
    if (!rst) begin
      mq.delete();
      m_busy = 0;
      m_len_err = 0;
      m_count = 0;
    end else begin
      m_len_err = 0;
      if (m_busy) begin
        if (rdy && mq.size() > 0) begin
          if (mq[0].eop) begin
            m_busy = 0;
            m_count = (m_count + 1) % 65536;
          end
          void'(mq.pop_front());
        end
      end else if (start) begin
        if (msg_len == 0) m_len_err = 1;
        else begin
          build(int'(msg_len), seed);
          m_busy = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("valid", valid, m_busy);
      chk("ready_for_start", rfs, !m_busy);
      chk("len_err", len_err, m_len_err);
      chk("msg_count", msg_count, m_count[15:0]);
      if (m_busy && mq.size() > 0) begin
        chk("data", data, mq[0].data);
        chk("sop", sop, mq[0].sop);
        chk("eop", eop, mq[0].eop);
        chk("empty", empty, mq[0].empty);
      end
      if (len_err) lenerr_seen++;
      if (valid) valid_cycles++;
      if (valid && rdy && rst) begin
        cap_data.push_back(data);
        cap_empty.push_back(empty);
        $display("beat data=%h sop=%0b eop=%0b empty=%0d", data, sop, eop, empty);
      end
    end
  end

  task automatic cmd(input int l, input logic [7:0] s);
    @(posedge clk); #1;
    start = 1'b1; msg_len = LW'(l); seed = s;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!m_busy) break;
    end
    total++;
    if (m_busy) begin
      bad++;
      $display("FAIL wait_idle: got busy expected idle within 400 cycles");
    end
  endtask

  task automatic clear_caps();
    cap_data.delete();
    cap_empty.delete();
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; msg_len = '0; seed = '0; rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1 checking = 1;
    @(posedge clk); #1;
    rst = 1'b1; rdy = 1'b1;

    // 10 bytes from seed 0 -> three beats, last with empty=2
    clear_caps();
    cmd(10, 8'h00);
    wait_idle();
    $display("msg len=10 seed=00 beats=%0d count=%0d", cap_data.size(), msg_count);
    chk("t1_beats", cap_data.size(), 3);
    chk("t1_b0", cap_data[0], 32'h00010203);
    chk("t1_b1", cap_data[1], 32'h04050607);
    chk("t1_b2", cap_data[2], 32'h08090000);
    chk("t1_empty", cap_empty[2], 2);
    chk("t1_count", msg_count, 1);

    // single beat with byte wrap
    clear_caps();
    cmd(4, 8'hFE);
    wait_idle();
    $display("msg len=4 seed=fe beats=%0d", cap_data.size());
    chk("t2_beats", cap_data.size(), 1);
    chk("t2_b0", cap_data[0], 32'hFEFF0001);
    chk("t2_empty", cap_empty[0], 0);
    chk("t2_count", msg_count, 2);

    // backpressure for three cycles on beat 2
    clear_caps();
    valid_cycles = 0;
    cmd(8, 8'h10);
    @(posedge clk); #1 rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1 rdy = 1'b1;
    wait_idle();
    $display("msg len=8 stalled beats=%0d valid_cycles=%0d", cap_data.size(), valid_cycles);
    chk("t3_beats", cap_data.size(), 2);
    chk("t3_b0", cap_data[0], 32'h10111213);
    chk("t3_b1", cap_data[1], 32'h14151617);
    chk("t3_valid_cycles", valid_cycles, 5);
    chk("t3_count", msg_count, 3);

    // zero length command
    lenerr_seen = 0;
    valid_cycles = 0;
    cmd(0, 8'h55);
    repeat (3) @(negedge clk);
    $display("msg len=0 len_err_cycles=%0d", lenerr_seen);
    chk("t4_len_err_cycles", lenerr_seen, 1);
    chk("t4_valid_cycles", valid_cycles, 0);
    chk("t4_count", msg_count, 3);

    // start during SEND is ignored
    clear_caps();
    cmd(20, 8'h30);
    @(posedge clk); #1;
    start = 1'b1; msg_len = 16'd100; seed = 8'h99;
    @(posedge clk); #1 start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    $display("msg len=20 with ignored start beats=%0d", cap_data.size());
    chk("t5_beats", cap_data.size(), 5);
    chk("t5_b0", cap_data[0], 32'h30313233);
    chk("t5_b4", cap_data[4], 32'h40414243);
    chk("t5_count", msg_count, 4);

    // reset on beat 2 abandons the message
    cmd(20, 8'h50);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    $display("reset mid-message valid=%0b rfs=%0b count=%0d", valid, rfs, msg_count);
    chk("t6_valid", valid, 0);
    chk("t6_rfs", rfs, 1);
    chk("t6_count", msg_count, 0);
    clear_caps();
    cmd(3, 8'h00);
    wait_idle();
    chk("t6_beats", cap_data.size(), 1);
    chk("t6_b0", cap_data[0], 32'h00010200);
    chk("t6_empty", cap_empty[0], 1);
    chk("t6_count_after", msg_count, 1);

    // random traffic with random backpressure and stray starts
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      rdy = ($urandom_range(0, 3) != 0);
      start = ($urandom_range(0, 7) == 0);
      msg_len = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 48));
      seed = 8'($urandom);
    end
    @(posedge clk); #1;
    start = 1'b0; rdy = 1'b1;
    wait_idle();
    repeat (2) @(negedge clk);

    checking = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
